// File: rtl/frac_clk_en_gen.sv
// Multi-channel fractional clock-enable generator.
// Each channel adds its increment to a phase accumulator every cycle once the
// synchronised PLL lock has been stable for LOCK_CYCLES; the accumulator carry
// becomes a registered one-cycle enable strobe at f_clk*inc/2^ACC_W.
module frac_clk_en_gen #(
    parameter int                  N_CH        = 2,
    parameter int                  ACC_W       = 32,
    parameter logic [ACC_W-1:0]    INIT_INC    = ACC_W'(32'h4000_0000),
    parameter int                  LOCK_CYCLES = 1024,
    localparam int                 CH_W        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             lock_in,
    output logic             ready,
    input  logic             wr_en,
    input  logic [CH_W-1:0]  wr_ch,
    input  logic [ACC_W-1:0] wr_inc,
    input  logic             wr_restart,
    input  logic             sync,
    output logic [N_CH-1:0]  ch_en
);

    localparam int CNT_W = $clog2(LOCK_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_CYCLES);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ready_q, ready_d;
    logic [ACC_W-1:0] acc_q [N_CH];
    logic [ACC_W-1:0] acc_d [N_CH];
    logic [ACC_W-1:0] inc_q [N_CH];
    logic [ACC_W-1:0] inc_d [N_CH];
    logic [N_CH-1:0]  ch_en_q, ch_en_d;

    logic             run;
    logic             wr_ok;
    int unsigned      wr_idx;
    logic [ACC_W:0]   sum;

    // Next-state: lock synchroniser/filter, increment writes, accumulators
    always_comb begin
        sync1_d = lock_in;
        sync2_d = sync1_q;

        if (!sync2_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        ready_d = sync2_q && (cnt_q == CNT_MAX);

        // Accumulate only when ready is held across this edge, so a lock
        // drop clears the accumulators on the same edge that drops ready.
        run    = ready_q && ready_d;
        wr_idx = 32'(wr_ch);
        wr_ok  = wr_en && (wr_idx < N_CH);
        sum    = '0;

        for (int unsigned i = 0; i < N_CH; i++) begin
            inc_d[i] = (wr_ok && (wr_idx == i)) ? wr_inc : inc_q[i];
            sum      = {1'b0, acc_q[i]} + {1'b0, inc_q[i]};
            if (!run || sync || (wr_en && wr_restart && (wr_idx == i))) begin
                acc_d[i]   = '0;
                ch_en_d[i] = 1'b0;
            end else begin
                acc_d[i]   = sum[ACC_W-1:0];
                ch_en_d[i] = sum[ACC_W];
            end
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            ch_en_q <= '0;
            for (int unsigned i = 0; i < N_CH; i++) begin
                acc_q[i] <= '0;
                inc_q[i] <= INIT_INC;
            end
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            ch_en_q <= ch_en_d;
            for (int unsigned i = 0; i < N_CH; i++) begin
                acc_q[i] <= acc_d[i];
                inc_q[i] <= inc_d[i];
            end
        end
    end

    assign ready = ready_q;
    assign ch_en = ch_en_q;

endmodule
